// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin arbiter that drives a register-file write port.
// Optional hardware clear sequence, enabled by RF_CLEAR_EN, writes 0 to registers 1..2^AW-1.
module regfile_wb_arbiter #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_e;

  localparam logic LG_A = 1'b0;
  localparam logic LG_B = 1'b1;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          we3_q, we3_d;
  logic [AW-1:0] wa3_q, wa3_d;
  logic [DW-1:0] wd3_q, wd3_d;

`ifdef RF_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;
`else
  logic unused_clr_start;
  assign unused_clr_start = clr_start;
`endif

  // Grant selection, write-port next value and clear sequencing.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_ready = 1'b0;
    b_ready = 1'b0;
    we3_d   = 1'b0;
    wa3_d   = wa3_q;
    wd3_d   = wd3_q;
`ifdef RF_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ARB: begin
        // On contention the requester not granted last time wins.
        if (a_valid && (!b_valid || last_q == LG_B)) begin
          a_ready = 1'b1;
        end else if (b_valid) begin
          b_ready = 1'b1;
        end
        if (a_ready) begin
          last_d = LG_A;
          we3_d  = (a_addr != '0);
          wa3_d  = a_addr;
          wd3_d  = a_data;
        end else if (b_ready) begin
          last_d = LG_B;
          we3_d  = (b_addr != '0);
          wa3_d  = b_addr;
          wd3_d  = b_data;
        end
`ifdef RF_CLEAR_EN
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
`endif
      end
      CLEAR: begin
`ifdef RF_CLEAR_EN
        we3_d = 1'b1;
        wa3_d = cnt_q;
        wd3_d = '0;
        // Leave on the last address rather than wrapping back to register 0.
        if (cnt_q == '1) begin
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
`else
        state_d = ARB;
`endif
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      last_q  <= LG_B;
      we3_q   <= 1'b0;
      wa3_q   <= '0;
      wd3_q   <= '0;
`ifdef RF_CLEAR_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we3_q   <= we3_d;
      wa3_q   <= wa3_d;
      wd3_q   <= wd3_d;
`ifdef RF_CLEAR_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign clr_busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus pushes the expected write-port
// value for each edge, a monitor pops and compares after that edge.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0, clr_start = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;
  logic          a_ready, b_ready, clr_busy, we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One arbitration cycle: drive, check readies, queue the write expected after the edge.
  task automatic cyc(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                     input logic cs, input logic ear, input logic ebr,
                     input logic ewe, input logic [AW-1:0] ewa, input logic [DW-1:0] ewd);
    exp_t e;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    clr_start = cs;
    #1;
    chk("a_ready", 64'(a_ready), 64'(ear));
    chk("b_ready", 64'(b_ready), 64'(ebr));
    e.we = ewe; e.wa = ewa; e.wd = ewd;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: compares the write port once per edge that has a queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("we3", 64'(we3), 64'(e.we));
      if (e.we) begin
        chk("wa3", 64'(wa3), 64'(e.wa));
        chk("wd3", 64'(wd3), 64'(e.wd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", 64'(wd3), 64'd0);
    chk("rst_clr_busy", 64'(clr_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention from reset: A, B, A, B.
    cyc(1, 5'd4, 32'hA0A0A0A0, 1, 5'd7, 32'hB0B0B0B0, 0, 1, 0, 1, 5'd4, 32'hA0A0A0A0);
    cyc(1, 5'd4, 32'hA0A0A0A0, 1, 5'd7, 32'hB0B0B0B0, 0, 0, 1, 1, 5'd7, 32'hB0B0B0B0);
    cyc(1, 5'd4, 32'hA0A0A0A0, 1, 5'd7, 32'hB0B0B0B0, 0, 1, 0, 1, 5'd4, 32'hA0A0A0A0);
    cyc(1, 5'd4, 32'hA0A0A0A0, 1, 5'd7, 32'hB0B0B0B0, 0, 0, 1, 1, 5'd7, 32'hB0B0B0B0);
    idle();
    // Single requester A.
    cyc(1, 5'd3, 32'hDEADBEEF, 0, '0, '0, 0, 1, 0, 1, 5'd3, 32'hDEADBEEF);
    idle();
    // B writes address 0: consumed, no write, B recorded as last grant.
    cyc(0, '0, '0, 1, 5'd0, 32'h12345678, 0, 0, 1, 0, '0, '0);
    cyc(1, 5'd9, 32'h00000099, 1, 5'd10, 32'h000000AA, 0, 1, 0, 1, 5'd9, 32'h00000099);
    // Back-to-back single-requester pulses with changing data.
    cyc(0, '0, '0, 1, 5'd31, 32'hFFFF0001, 0, 0, 1, 1, 5'd31, 32'hFFFF0001);
    cyc(1, 5'd1, 32'h00000001, 0, '0, '0, 0, 1, 0, 1, 5'd1, 32'h00000001);
    idle();

`ifdef RF_CLEAR_EN
    // Clear start with A requesting: grant still happens at that edge.
    cyc(1, 5'd2, 32'hCAFE0002, 0, '0, '0, 1, 1, 0, 1, 5'd2, 32'hCAFE0002);
    for (int k = 1; k <= 31; k++) begin
      // Requests and a repeated clr_start are ignored during the clear.
      cyc(1, 5'd2, 32'h1, 1, 5'd3, 32'h2, (k == 5), 0, 0, 1, AW'(k), '0);
      chk("clr_busy_on", 64'(clr_busy), 64'd1);
    end
    // Back in ARB; A held last grant, so B wins contention.
    cyc(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, 0, 1, 1, 5'd8, 32'h88);
    chk("clr_busy_off", 64'(clr_busy), 64'd0);
    idle();
    // Second clear, aborted by reset while wa3 is 10.
    cyc(0, '0, '0, 0, '0, '0, 1, 0, 0, 0, '0, '0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, '0, '0, 0, '0, '0, 0, 0, 0, 1, AW'(k), '0);
    end
    @(negedge clk);
    chk("pre_rst_wa3", 64'(wa3), 64'd10);
    rst_n = 1'b0;
    #1;
    chk("arst_we3", 64'(we3), 64'd0);
    chk("arst_wa3", 64'(wa3), 64'd0);
    chk("arst_wd3", 64'(wd3), 64'd0);
    chk("arst_clr_busy", 64'(clr_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // ARB after release with last grant back to B: A wins.
    cyc(1, 5'd12, 32'h0C0C0C0C, 1, 5'd13, 32'h0D0D0D0D, 0, 1, 0, 1, 5'd12, 32'h0C0C0C0C);
    chk("post_rst_clr_busy", 64'(clr_busy), 64'd0);
    idle();
`else
    // clr_start has no effect: A granted, then B wins contention next.
    cyc(1, 5'd2, 32'hCAFE0002, 0, '0, '0, 1, 1, 0, 1, 5'd2, 32'hCAFE0002);
    chk("clr_busy_off0", 64'(clr_busy), 64'd0);
    cyc(1, 5'd6, 32'h66, 1, 5'd8, 32'h88, 0, 0, 1, 1, 5'd8, 32'h88);
    chk("clr_busy_off1", 64'(clr_busy), 64'd0);
    idle();
    chk("clr_busy_off2", 64'(clr_busy), 64'd0);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
